// File: rtl/abc_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : abc_input_pkg
//  Description : Shared types and default timing constants for the ABC
//                operand input stage (debounced switches plus sweep mode).
//  Revision    : 1.0 - initial release
// ============================================================================
package abc_input_pkg;

  // Operand source: the slide switches or the free-running 3-bit sweep
  typedef enum logic [0:0] {
    MANUAL = 1'b0,
    SWEEP  = 1'b1
  } mode_t;

  // 5 ms of stable level at 100 MHz before a switch change is accepted
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // One sweep step per second at 100 MHz
  localparam int DEFAULT_STEP_CYCLES = 100000000;

endpackage : abc_input_pkg
`default_nettype wire

// File: rtl/abc_input_stage_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : debounce
//  Description : Two-flop synchronizer followed by a stability counter. The
//                debounced level follows the synchronized input only after
//                the two have differed for DEBOUNCE_CYCLES consecutive cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce
  import abc_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q,  sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] count_q, count_d;

  // Next state: shift the synchronizer, count consecutive mismatch cycles
  always_comb begin
    sync_d  = {sync_q[0], i_raw};
    level_d = level_q;
    count_d = '0;
    if (sync_q[1] != level_q) begin
      // The final mismatch cycle commits the new level and restarts counting
      if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any debounce progress in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  assign o_level = level_q;

endmodule : debounce
`default_nettype wire

// File: rtl/abc_input_stage.sv
`default_nettype none
// ============================================================================
//  Module      : abc_input_stage
//  Description : Produces registered operands A/B/C either from three
//                debounced slide switches (MANUAL) or from a slow 3-bit
//                counter (SWEEP). A debounced push-button toggles the mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module abc_input_stage
  import abc_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int STEP_CYCLES     = DEFAULT_STEP_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a,
  input  logic sw_b,
  input  logic sw_c,
  input  logic btn_mode,
  output logic A,
  output logic B,
  output logic C,
  output logic abc_changed,
  output logic sweep_mode
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  // Bit 3 is the mode button, bits 2..0 are the switches in A,B,C order
  logic [3:0] w_raw;
  logic [3:0] w_db;
  logic [2:0] w_sw_db;
  logic       w_btn_db;
  logic       w_btn_rise;

  assign w_raw    = {btn_mode, sw_a, sw_b, sw_c};
  assign w_sw_db  = w_db[2:0];
  assign w_btn_db = w_db[3];

  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (w_raw[gi]),
      .o_level (w_db[gi])
    );
  end

  mode_t         mode_q,     mode_d;
  logic          btn_prev_q, btn_prev_d;
  logic [2:0]    cnt_q,      cnt_d;
  logic [TW-1:0] timer_q,    timer_d;
  logic [2:0]    abc_q,      abc_d;
  logic [2:0]    abc_prev_q, abc_prev_d;
  logic          chg_q,      chg_d;

  assign w_btn_rise = w_btn_db & ~btn_prev_q;

  // Mode FSM, sweep counter and operand selection; a button edge takes
  // priority over a sweep step landing in the same cycle
  always_comb begin
    mode_d     = mode_q;
    btn_prev_d = w_btn_db;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    abc_d      = abc_q;
    abc_prev_d = abc_q;
    chg_d      = (abc_q != abc_prev_q);

    case (mode_q)
      MANUAL: begin
        if (w_btn_rise) begin
          // Start the sweep from 000 with a full step period ahead
          mode_d  = SWEEP;
          cnt_d   = 3'b000;
          timer_d = '0;
          abc_d   = 3'b000;
        end else begin
          abc_d = w_sw_db;
        end
      end

      SWEEP: begin
        if (w_btn_rise) begin
          // Back to the switches immediately; the sweep position is dropped
          mode_d = MANUAL;
          abc_d  = w_sw_db;
        end else begin
          if (timer_q == TW'(STEP_CYCLES - 1)) begin
            timer_d = '0;
            cnt_d   = cnt_q + 3'd1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
          abc_d = cnt_d;
        end
      end

      default: begin
        mode_d = MANUAL;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= MANUAL;
      btn_prev_q <= 1'b0;
      cnt_q      <= '0;
      timer_q    <= '0;
      abc_q      <= '0;
      abc_prev_q <= '0;
      chg_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      btn_prev_q <= btn_prev_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      abc_q      <= abc_d;
      abc_prev_q <= abc_prev_d;
      chg_q      <= chg_d;
    end
  end

  assign A           = abc_q[2];
  assign B           = abc_q[1];
  assign C           = abc_q[0];
  assign abc_changed = chg_q;
  assign sweep_mode  = (mode_q == SWEEP);

endmodule : abc_input_stage
`default_nettype wire

// File: tb/tb_abc_input_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_abc_input_stage
//  Description : Directed self-checking bench for abc_input_stage with
//                DEBOUNCE_CYCLES=4 and STEP_CYCLES=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_abc_input_stage;

  logic clk;
  logic rst_n;
  logic sw_a, sw_b, sw_c, btn_mode;
  logic A, B, C, abc_changed, sweep_mode;

  int vectors;
  int miscompares;

  abc_input_stage #(
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES    (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_a        (sw_a),
    .sw_b        (sw_b),
    .sw_c        (sw_c),
    .btn_mode    (btn_mode),
    .A           (A),
    .B           (B),
    .C           (C),
    .abc_changed (abc_changed),
    .sweep_mode  (sweep_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst_n = 1'b0; sw_a = 1'b0; sw_b = 1'b0; sw_c = 1'b0; btn_mode = 1'b0;
    tick();
    obs = {A, B, C, sweep_mode, abc_changed};
    vectors++;
    if (obs !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_held: {A,B,C,sweep,chg}=%b expected 00000", obs);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      obs = {A, B, C, sweep_mode, abc_changed};
      vectors++;
      if (obs !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: {A,B,C,sweep,chg}=%b expected 00000", i, obs);
      end
    end
  endtask

  // sw_a rises after edge t: A=1 from edge t+7, pulse at t+8 only
  task automatic test_latency();
    logic [2:0] exp_abc;
    logic       exp_chg;
    sw_a = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_abc = (i >= 7) ? 3'b100 : 3'b000;
      exp_chg = (i == 8);
      vectors++;
      if ({A, B, C} !== exp_abc || abc_changed !== exp_chg || sweep_mode !== 1'b0) begin
        miscompares++;
        $display("FAIL latency cyc%0d: abc=%b chg=%b sweep=%b expected abc=%b chg=%b sweep=0",
                 i, {A, B, C}, abc_changed, sweep_mode, exp_abc, exp_chg);
      end
    end
  endtask

  // Three-cycle sw_b pulse is shorter than the debounce window
  task automatic test_glitch();
    sw_b = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      vectors++;
      if ({A, B, C} !== 3'b100 || abc_changed !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch cyc%0d: abc=%b chg=%b expected abc=100 chg=0",
                 i, {A, B, C}, abc_changed);
      end
      if (i == 3) sw_b = 1'b0;
    end
  endtask

  // Button press: SWEEP from edge t+7, value v from t+7+3v, full wrap
  task automatic test_sweep();
    logic [2:0] exp_abc;
    logic       exp_chg;
    logic       exp_sweep;
    btn_mode = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      exp_sweep = (i >= 7);
      exp_abc   = (i < 7) ? 3'b100 : 3'(((i - 7) / 3) % 8);
      exp_chg   = (i >= 8) && (((i - 8) % 3) == 0);
      vectors++;
      if ({A, B, C} !== exp_abc || abc_changed !== exp_chg || sweep_mode !== exp_sweep) begin
        miscompares++;
        $display("FAIL sweep cyc%0d: abc=%b chg=%b sweep=%b expected abc=%b chg=%b sweep=%b",
                 i, {A, B, C}, abc_changed, sweep_mode, exp_abc, exp_chg, exp_sweep);
      end
      if (i == 10) btn_mode = 1'b0;
    end
  endtask

  // Switch changes while sweeping, then a second press returns to MANUAL=001
  task automatic test_exit();
    sw_a = 1'b0;
    sw_c = 1'b1;
    for (int j = 1; j <= 8; j++) tick();
    btn_mode = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 6) begin
        vectors++;
        if ({A, B, C} !== 3'b101 || sweep_mode !== 1'b1) begin
          miscompares++;
          $display("FAIL exit_pre: abc=%b sweep=%b expected abc=101 sweep=1",
                   {A, B, C}, sweep_mode);
        end
      end else if (j >= 7) begin
        vectors++;
        if ({A, B, C} !== 3'b001 || sweep_mode !== 1'b0 || abc_changed !== (j == 8)) begin
          miscompares++;
          $display("FAIL exit cyc%0d: abc=%b sweep=%b chg=%b expected abc=001 sweep=0 chg=%b",
                   j, {A, B, C}, sweep_mode, abc_changed, (j == 8));
        end
      end
      if (j == 10) btn_mode = 1'b0;
    end
  endtask

  // Reset while sweeping at cnt=5, then sw_c (still high) re-debounces
  task automatic test_reset_mid_sweep();
    btn_mode = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (i == 23) begin
        vectors++;
        if ({A, B, C} !== 3'b101 || sweep_mode !== 1'b1) begin
          miscompares++;
          $display("FAIL rst_pre: abc=%b sweep=%b expected abc=101 sweep=1",
                   {A, B, C}, sweep_mode);
        end
        rst_n = 1'b0;
      end else if (i == 24) begin
        vectors++;
        if ({A, B, C, sweep_mode, abc_changed} !== 5'b0) begin
          miscompares++;
          $display("FAIL rst_mid: {A,B,C,sweep,chg}=%b expected 00000",
                   {A, B, C, sweep_mode, abc_changed});
        end
        rst_n = 1'b1;
      end else if (i >= 25) begin
        vectors++;
        if ({A, B, C} !== ((i >= 31) ? 3'b001 : 3'b000) || sweep_mode !== 1'b0 ||
            abc_changed !== (i == 32)) begin
          miscompares++;
          $display("FAIL rst_post cyc%0d: abc=%b sweep=%b chg=%b expected abc=%b sweep=0 chg=%b",
                   i, {A, B, C}, sweep_mode, abc_changed,
                   ((i >= 31) ? 3'b001 : 3'b000), (i == 32));
        end
      end
      if (i == 10) btn_mode = 1'b0;
    end
  endtask

  // Second press lands on the same edge as the 5->6 step: mode change wins
  task automatic test_collision();
    btn_mode = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 24) begin
        vectors++;
        if ({A, B, C} !== 3'b101 || sweep_mode !== 1'b1) begin
          miscompares++;
          $display("FAIL collide_pre: abc=%b sweep=%b expected abc=101 sweep=1",
                   {A, B, C}, sweep_mode);
        end
      end else if (i >= 25) begin
        vectors++;
        if ({A, B, C} !== 3'b001 || sweep_mode !== 1'b0 || abc_changed !== (i == 26)) begin
          miscompares++;
          $display("FAIL collide cyc%0d: abc=%b sweep=%b chg=%b expected abc=001 sweep=0 chg=%b",
                   i, {A, B, C}, sweep_mode, abc_changed, (i == 26));
        end
      end
      if (i == 10) btn_mode = 1'b0;
      if (i == 18) btn_mode = 1'b1;
      if (i == 28) btn_mode = 1'b0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_sweep();
    test_exit();
    test_reset_mid_sweep();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_abc_input_stage
`default_nettype wire

// File: doc/abc_input_stage.md
ABC_INPUT_STAGE -- requirements
Module: abc_input_stage

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive cycles a synchronized input must differ from its debounced value before the debounced value changes (5 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 Parameter STEP_CYCLES, default 100000000: cycles per step of the sweep counter in SWEEP mode (1 s at 100 MHz); legal range 2..2^27-1.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 sw_a, sw_b, sw_c  input  1 each  raw, asynchronous, bouncing slide-switch levels.
REQ-006 btn_mode  input  1  raw, asynchronous, bouncing push-button, active-high.
REQ-007 A, B, C  output  1 each  registered operands for the downstream four-function logic.
REQ-008 abc_changed  output  1  one-cycle pulse in the cycle after {A,B,C} takes a new value.
REQ-009 sweep_mode  output  1  1 when the FSM is in SWEEP, 0 in MANUAL.

Function
REQ-010 Each of sw_a, sw_b, sw_c, btn_mode SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Debounce, per input: counter cleared whenever the synchronized value equals the debounced value; incremented while they differ; on the cycle the count reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the debounced value SHALL take the synchronized value and the counter SHALL clear.
REQ-012 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change any debounced value.
REQ-013 Latency, MANUAL: a raw switch held at a new level from cycle t SHALL appear on A/B/C at cycle t+3+DEBOUNCE_CYCLES (2 sync + DEBOUNCE_CYCLES debounce + 1 output register).
REQ-014 FSM states: MANUAL (reset state) and SWEEP; a rising edge of debounced btn_mode SHALL toggle the state; no other transitions.
REQ-015 MANUAL: {A,B,C} SHALL register {db_a,db_b,db_c} every cycle.
REQ-016 SWEEP: 3-bit counter cnt drives {A,B,C} = {cnt[2],cnt[1],cnt[0]}; step timer counts 0..STEP_CYCLES-1; at terminal count cnt SHALL increment and the timer SHALL clear.
REQ-017 cnt SHALL wrap 7 -> 0 with no stall or skipped value.
REQ-018 Entering SWEEP: cnt and step timer SHALL clear in the transition cycle, so {A,B,C}=000 on the next cycle and the first step occurs STEP_CYCLES cycles later.
REQ-019 Leaving SWEEP: {A,B,C} SHALL take the current debounced switches on the next cycle; cnt value is discarded.
REQ-020 Switch activity in SWEEP SHALL continue to be debounced but SHALL NOT affect A/B/C.
REQ-021 abc_changed SHALL be 1 for exactly one cycle following any cycle in which the registered {A,B,C} differs from its previous value, including mode-change jumps; never asserted in the cycle after reset release.
REQ-022 A mode-button edge coinciding with a sweep step: the mode transition SHALL win; the step is dropped.

Reset
REQ-023 While rst_n=0 at a clk edge: synchronizers, debounced values, debounce counters, step timer, cnt -> 0; FSM -> MANUAL; A=B=C=0; abc_changed=0; sweep_mode=0.
REQ-024 Reset asserted mid-debounce or mid-sweep SHALL abandon all progress; no held-button edge SHALL be detected from the debounced button rising from reset value 0 unless it is seen as 1 for DEBOUNCE_CYCLES after release.

Structure
REQ-025 Package abc_input_pkg SHALL hold the mode_t enum (MANUAL, SWEEP) and the default DEBOUNCE_CYCLES/STEP_CYCLES constants.
REQ-026 Sub-module debounce (synchronizer + counter, parameterized by DEBOUNCE_CYCLES) SHALL be instantiated four times; FSM, sweep counter and output register stay in abc_input_stage.

Verification (DEBOUNCE_CYCLES=4, STEP_CYCLES=3)
REQ-027 Reset release, all raw inputs 0 -> A=B=C=0, sweep_mode=0, abc_changed never asserted for 20 cycles.
REQ-028 sw_a 0->1 at cycle 10, held -> A=1 at cycle 17, abc_changed=1 at cycle 18 only.
REQ-029 sw_b pulses 1 for 3 cycles then 0 -> B stays 0 throughout, abc_changed stays 0.
REQ-030 btn_mode held 1 for 10 cycles -> sweep_mode=1; {A,B,C} steps 000,001,...,111,000 each 3 cycles, abc_changed pulsing once per step.
REQ-031 Second btn_mode press in SWEEP with sw_c=1 debounced -> sweep_mode=0, {A,B,C}=001 next cycle, one abc_changed pulse.
REQ-032 rst_n=0 for one cycle during SWEEP at cnt=5 -> next cycle A=B=C=0, sweep_mode=0, counters zero.
